unidade_controle_multiciclo: RTL and testbench

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

---
 rtl/unidade_controle_multiciclo.sv | 164 ++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: BUSCA/DECOD/EXEC/MEM/ESCR/PARADO sequencer
// with memory-wait timeout, sticky fault flags and retired-instruction count.
module unidade_controle_multiciclo #(
  parameter int              OPW         = 8,
  parameter logic [OPW-1:0]  OP_HALT     = '1,
  parameter int              MEM_TIMEOUT = 15,
  parameter int              CNTW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  instru,
  input  logic            mem_pronto,
  output logic            escrita,
  output logic            escritaPC,
  output logic            ulaFonte,
  output logic            ulaOP,
  output logic            pula,
  output logic            regFonte,
  output logic            comparador,
  output logic            lerMemo,
  output logic            escreveMemo,
  output logic [2:0]      estado,
  output logic            parado,
  output logic            instr_invalida,
  output logic            erro_mem,
  output logic [CNTW-1:0] retiradas
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  localparam logic [OPW-1:0] OP_ESC  = OPW'(0);
  localparam logic [OPW-1:0] OP_IMM  = OPW'(1);
  localparam logic [OPW-1:0] OP_ULA  = OPW'(2);
  localparam logic [OPW-1:0] OP_PULA = OPW'(3);
  localparam logic [OPW-1:0] OP_REG  = OPW'(4);
  localparam logic [OPW-1:0] OP_CMP  = OPW'(5);
  localparam logic [OPW-1:0] OP_LD   = OPW'(6);
  localparam logic [OPW-1:0] OP_ST   = OPW'(7);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(8);

  typedef enum logic [2:0] {
    BUSCA  = 3'd0,
    DECOD  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    ESCR   = 3'd4,
    PARADO = 3'd5
  } estado_t;

  estado_t        st;
  logic [OPW-1:0] ir;
  logic [WW-1:0]  wcnt;
  logic           valido;
  logic           eh_mem;
  logic           curto;

  assign valido = (ir <= OP_NOP);
  assign eh_mem = (ir == OP_LD) || (ir == OP_ST);
  assign curto  = (ir == OP_PULA) || (ir == OP_NOP);

  // State sequencing, opcode capture, memory wait counter and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= BUSCA;
      ir             <= '0;
      wcnt           <= '0;
      retiradas      <= '0;
      instr_invalida <= 1'b0;
      erro_mem       <= 1'b0;
    end else begin
      case (st)
        BUSCA: begin
          ir <= instru;
          st <= DECOD;
        end
        DECOD: begin
          st <= (ir == OP_HALT) ? PARADO : EXEC;
        end
        EXEC: begin
          wcnt <= '0;
          if (!valido) begin
            instr_invalida <= 1'b1;
            st             <= BUSCA;
          end else if (eh_mem) begin
            st <= MEM;
          end else if (curto) begin
            retiradas <= retiradas + CNTW'(1);
            st        <= BUSCA;
          end else begin
            st <= ESCR;
          end
        end
        MEM: begin
          if (mem_pronto) begin
            wcnt <= '0;
            if (ir == OP_LD) begin
              st <= ESCR;
            end else begin
              retiradas <= retiradas + CNTW'(1);
              st        <= BUSCA;
            end
          end else if (wcnt == WLAST) begin
            wcnt     <= '0;
            erro_mem <= 1'b1;
            st       <= BUSCA;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ESCR: begin
          retiradas <= retiradas + CNTW'(1);
          st        <= BUSCA;
        end
        PARADO: begin
          st <= PARADO;
        end
        default: begin
          st <= BUSCA;
        end
      endcase
    end
  end

  // Control strobes from state and ir; reset silences them at once
  always_comb begin
    escrita     = 1'b0;
    escritaPC   = 1'b0;
    ulaFonte    = 1'b0;
    ulaOP       = 1'b0;
    pula        = 1'b0;
    regFonte    = 1'b0;
    comparador  = 1'b0;
    lerMemo     = 1'b0;
    escreveMemo = 1'b0;
    parado      = 1'b0;
    if (!reset) begin
      unique case (st)
        BUSCA: escritaPC = 1'b1;
        EXEC: begin
          ulaFonte   = (ir == OP_IMM);
          ulaOP      = (ir == OP_ULA);
          regFonte   = (ir == OP_REG);
          comparador = (ir == OP_CMP);
          pula       = (ir == OP_PULA);
          escritaPC  = (ir == OP_PULA);
        end
        MEM: begin
          lerMemo     = (ir == OP_LD);
          escreveMemo = (ir == OP_ST);
        end
        ESCR:   escrita = 1'b1;
        PARADO: parado  = 1'b1;
        default: ;
      endcase
    end
  end

  assign estado = st;

  logic unused_esc;
  assign unused_esc = (OP_ESC == '0);

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: random instruction stream,
// per-instruction expectations queued and checked by a monitor.
module tb_unidade_controle_multiciclo;

  localparam int TMO = 15;

  logic       clk;
  logic       reset;
  logic [7:0] instru;
  logic       mem_pronto;
  logic       escrita, escritaPC, ulaFonte, ulaOP, pula;
  logic       regFonte, comparador, lerMemo, escreveMemo;
  logic [2:0] estado;
  logic       parado, instr_invalida, erro_mem;
  logic [3:0] retiradas;

  unidade_controle_multiciclo #(
    .OPW(8), .OP_HALT(8'hFF), .MEM_TIMEOUT(TMO), .CNTW(4)
  ) dut (
    .clk(clk), .reset(reset), .instru(instru), .mem_pronto(mem_pronto),
    .escrita(escrita), .escritaPC(escritaPC), .ulaFonte(ulaFonte),
    .ulaOP(ulaOP), .pula(pula), .regFonte(regFonte),
    .comparador(comparador), .lerMemo(lerMemo),
    .escreveMemo(escreveMemo), .estado(estado), .parado(parado),
    .instr_invalida(instr_invalida), .erro_mem(erro_mem),
    .retiradas(retiradas)
  );

  typedef struct {
    int op;
    int cyc, pc, wr, lr, em, ula, uop, pula, rf, cmp;
    int ret, inv, err;
  } rec_t;

  rec_t q[$];
  rec_t acc;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ret   = 0;
  int   m_inv   = 0;
  int   m_err   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Spec-level model: cycle count and strobe tallies per opcode.
  task automatic model(input int op, input int w, output rec_t r);
    bit ok;
    bit done;
    int n;
    r = '{default: 0};
    r.op = op;
    r.cyc = 3;
    r.pc = 1;
    ok = 1;
    if (op == 255) begin
      r.cyc = 2;
      ok = 0;
    end else if (op > 8) begin
      m_inv = 1;
      ok = 0;
    end else begin
      case (op)
        0, 1, 2, 4, 5: begin
          r.cyc = 4;
          r.wr = 1;
          r.ula = (op == 1);
          r.uop = (op == 2);
          r.rf = (op == 4);
          r.cmp = (op == 5);
        end
        3: begin
          r.pc = 2;
          r.pula = 1;
        end
        6, 7: begin
          done = (w >= 1 && w <= TMO);
          n = done ? w : TMO;
          if (op == 6) r.lr = n;
          else r.em = n;
          r.cyc = 3 + n;
          if (!done) begin
            m_err = 1;
            ok = 0;
          end else if (op == 6) begin
            r.wr = 1;
            r.cyc = r.cyc + 1;
          end
        end
        default: ;
      endcase
    end
    if (ok) m_ret = (m_ret + 1) % 16;
    r.ret = m_ret;
    r.inv = m_inv;
    r.err = m_err;
  endtask

  task automatic cmp_rec(input rec_t a, input rec_t e);
    string p;
    p = $sformatf("op%0d", e.op);
    chk({p, "_cycles"}, a.cyc, e.cyc);
    chk({p, "_escritaPC"}, a.pc, e.pc);
    chk({p, "_escrita"}, a.wr, e.wr);
    chk({p, "_lerMemo"}, a.lr, e.lr);
    chk({p, "_escreveMemo"}, a.em, e.em);
    chk({p, "_ulaFonte"}, a.ula, e.ula);
    chk({p, "_ulaOP"}, a.uop, e.uop);
    chk({p, "_pula"}, a.pula, e.pula);
    chk({p, "_regFonte"}, a.rf, e.rf);
    chk({p, "_comparador"}, a.cmp, e.cmp);
    chk({p, "_retiradas"}, a.ret, e.ret);
    chk({p, "_instr_invalida"}, a.inv, e.inv);
    chk({p, "_erro_mem"}, a.err, e.err);
  endtask

  task automatic finalize();
    rec_t e;
    acc.ret = int'(retiradas);
    acc.inv = int'(instr_invalida);
    acc.err = int'(erro_mem);
    if (q.size() == 0) begin
      chk("queue_underflow", 1, 0);
    end else begin
      e = q.pop_front();
      cmp_rec(acc, e);
    end
    acc = '{default: 0};
  endtask

  // Monitor: tally strobes per instruction, compare when it ends
  initial begin
    acc = '{default: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        acc = '{default: 0};
      end else begin
        chk("mem_strobe_exclusive", int'(lerMemo & escreveMemo), 0);
        if ((estado == 3'd0 || estado == 3'd5) && acc.cyc > 0)
          finalize();
        if (estado != 3'd5) begin
          acc.cyc++;
          acc.pc   += int'(escritaPC);
          acc.wr   += int'(escrita);
          acc.lr   += int'(lerMemo);
          acc.em   += int'(escreveMemo);
          acc.ula  += int'(ulaFonte);
          acc.uop  += int'(ulaOP);
          acc.pula += int'(pula);
          acc.rf   += int'(regFonte);
          acc.cmp  += int'(comparador);
        end
      end
    end
  end

  // Called at a negedge in BUSCA; returns at the next BUSCA or PARADO.
  // w is the MEM cycle on which mem_pronto rises (out of range: never).
  task automatic issue(input int op, input int w);
    rec_t r;
    int g;
    int k;
    g = 0;
    while (estado != 3'd0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("wait_busca_timeout", 1, 0);
    instru = 8'(op);
    mem_pronto = 1'($urandom_range(0, 1));
    model(op, w, r);
    q.push_back(r);
    k = 0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
      if (estado == 3'd3) begin
        k++;
        mem_pronto = (k == w);
      end else begin
        mem_pronto = 1'($urandom_range(0, 1));
        instru = 8'($urandom);
      end
    end while (estado != 3'd0 && estado != 3'd5 && g < 100);
    if (g >= 100) chk("instr_end_timeout", 1, 0);
  endtask

  task automatic model_reset();
    m_ret = 0;
    m_inv = 0;
    m_err = 0;
    q.delete();
  endtask

  initial begin
    int op;
    int g;
    int bad;
    reset = 1'b1;
    instru = 8'h00;
    mem_pronto = 1'b0;
    #12;
    chk("rst_estado", int'(estado), 0);
    chk("rst_escritaPC", int'(escritaPC), 0);
    chk("rst_retiradas", int'(retiradas), 0);
    chk("rst_flags", int'({instr_invalida, erro_mem, parado}), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    issue(0, 0);
    issue(6, 3);
    issue(7, 0);
    issue(8'h2A, 0);
    issue(1, 0);

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 9);
      if (op == 9) op = $urandom_range(9, 254);
      issue(op, $urandom_range(1, 17));
    end

    for (int i = 0; i < 17; i++) issue(8, 0);

    instru = 8'h07;
    mem_pronto = 1'b0;
    g = 0;
    k_loop: while (g < 40) begin
      @(negedge clk);
      instru = 8'($urandom);
      g++;
      if (estado == 3'd3) break;
    end
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_escreveMemo", int'(escreveMemo), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midmem_escreveMemo", int'(escreveMemo), 0);
    chk("midmem_estado", int'(estado), 0);
    chk("midmem_escritaPC", int'(escritaPC), 0);
    chk("midmem_retiradas", int'(retiradas), 0);
    chk("midmem_flags", int'({instr_invalida, erro_mem}), 0);
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    issue(2, 0);
    issue(5, 0);

    issue(255, 0);
    chk("halt_parado", int'(parado), 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      mem_pronto = 1'($urandom_range(0, 1));
      if (parado !== 1'b1 || estado != 3'd5 ||
          {escrita, escritaPC, ulaFonte, ulaOP, pula,
           regFonte, comparador, lerMemo, escreveMemo} != '0)
        bad++;
    end
    chk("halt_hold_100", bad, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("post_halt_estado", int'(estado), 0);
    chk("post_halt_parado", int'(parado), 0);
    chk("post_halt_escritaPC", int'(escritaPC), 1);
    chk("post_halt_flags", int'({instr_invalida, erro_mem}), 0);
    chk("post_halt_retiradas", int'(retiradas), 0);
    @(negedge clk);
    issue(0, 0);
    issue(6, 1);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
